// File: rtl/dsp_mem_arbiter.sv
// Round-robin arbiter with burst lock sharing one coefficient-memory port
// between two dsp requesters; read data is routed back to its issuer.
module dsp_mem_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 14,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              memen,
    output logic              memwe,
    output logic [ADDR_W-1:0] memaddr,
    output logic [DATA_W-1:0] memdin,
    input  logic [DATA_W-1:0] memdout
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {NONE, R0, R1} owner_t;

    owner_t        owner;
    logic          last;
    logic [CW-1:0] burst_cnt;
    logic [MEM_LAT:0] tag_v;
    logic [MEM_LAT:0] tag_id;

    logic   acc;
    logic   aid;
    owner_t aown;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            gnt0 = 1'b0;
        end else if (owner == R0 && req0 && (burst_cnt < CMAX || !req1)) begin
            gnt0 = 1'b1;
        end else if (owner == R1 && req1 && (burst_cnt < CMAX || !req0)) begin
            gnt1 = 1'b1;
        end else if (owner == R0 && req1) begin
            gnt1 = 1'b1;
        end else if (owner == R1 && req0) begin
            gnt0 = 1'b1;
        end else if (req0 && req1) begin
            gnt0 = last;
            gnt1 = !last;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    assign acc  = gnt0 | gnt1;
    assign aid  = gnt1;
    assign aown = aid ? R1 : R0;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= NONE;
            last      <= 1'b1;
            burst_cnt <= '0;
            memen     <= 1'b0;
            memwe     <= 1'b0;
            memaddr   <= '0;
            memdin    <= '0;
            tag_v     <= '0;
            tag_id    <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            // last tracks the most recent new owner, so ties go to the other side
            if (acc) begin
                if (owner == aown) begin
                    if (burst_cnt != CMAX)
                        burst_cnt <= burst_cnt + CW'(1);
                end else begin
                    owner     <= aown;
                    burst_cnt <= CW'(1);
                    last      <= aid;
                end
            end else if ((owner == R0 && !req0) || (owner == R1 && !req1)) begin
                owner     <= NONE;
                burst_cnt <= '0;
            end

            memen <= acc;
            memwe <= acc & (aid ? we1 : we0);
            if (acc) begin
                memaddr <= aid ? addr1 : addr0;
                memdin  <= aid ? wdata1 : wdata0;
            end

            tag_v[0]  <= acc & !(aid ? we1 : we0);
            tag_id[0] <= aid;
            for (int k = 1; k <= MEM_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end

            rvalid0 <= tag_v[MEM_LAT] & !tag_id[MEM_LAT];
            rvalid1 <= tag_v[MEM_LAT] & tag_id[MEM_LAT];
            if (tag_v[MEM_LAT] && !tag_id[MEM_LAT])
                rdata0 <= memdout;
            if (tag_v[MEM_LAT] && tag_id[MEM_LAT])
                rdata1 <= memdout;
        end
    end

endmodule
